// File: rtl/matrix_element_buffer.sv
// Matrix staging buffer in front of the FPU datapath.
// A load command captures an M x N matrix streamed in row-major order.
// A store command replays the held matrix with row/column tags.
// The shared packages are kept in this file so the block stands alone.

package bit_width;
    localparam int INWIDTH = 16;
endpackage

package matrix_pkg;
    typedef enum logic [1:0] {
        MAT_NOP   = 2'd0,
        MAT_LOAD  = 2'd1,
        MAT_STORE = 2'd2
    } matrix_operation_t;
endpackage

// Handshake semantics, identical on all three channels (op, in, out):
// a transfer happens on a rising clk edge where valid && ready are both
// high. The producer holds valid and its payload stable until that edge.
// The ready signals here depend only on the registered state, never on
// the matching valid.
module matrix_element_buffer
    import matrix_pkg::*;
#(
    parameter int M      = 3,
    parameter int N      = 3,
    parameter int DATA_W = bit_width::INWIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  matrix_operation_t                    op_in,
    input  logic                                 op_valid,
    output logic                                 op_ready,
    input  logic [DATA_W-1:0]                    in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [DATA_W-1:0]                    out_data,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] out_row,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_col,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 full,
    output logic                                 load_done,
    output logic                                 store_done,
    output logic                                 cmd_error,
    output logic [1:0]                           state_dbg
);

    localparam int DEPTH = M * N;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_W = (M > 1) ? $clog2(M) : 1;
    localparam int COL_W = (N > 1) ? $clog2(N) : 1;
    // A single-element matrix still has a 1-bit index, so give the array
    // two slots to keep index width and array size consistent; the second
    // slot is never written.
    localparam int BUF_D = (DEPTH > 1) ? DEPTH : 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FULL  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [IDX_W-1:0]   idx_nxt;
    logic [ROW_W-1:0]   row_nxt;
    logic [COL_W-1:0]   col_nxt;
    logic [DATA_W-1:0]  buffer [BUF_D];

    // Row-major position following the current one (col wraps, then row steps).
    always_comb begin
        idx_nxt = idx + 1'b1;
        row_nxt = row;
        col_nxt = col + 1'b1;
        if (col == LAST_COL) begin
            col_nxt = '0;
            row_nxt = row + 1'b1;
        end
    end

    // Control FSM, element counters, done/error pulses and the element store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            load_done  <= 1'b0;
            store_done <= 1'b0;
            cmd_error  <= 1'b0;
            for (int i = 0; i < BUF_D; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            load_done  <= 1'b0;
            store_done <= 1'b0;
            cmd_error  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_in)
                            MAT_LOAD: begin
                                state <= S_LOAD;
                                idx   <= '0;
                                row   <= '0;
                                col   <= '0;
                            end
                            MAT_NOP:  ;
                            // Nothing is held yet, so a store is illegal here.
                            default:  cmd_error <= 1'b1;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        buffer[idx] <= in_data;
                        if (idx == LAST_IDX) begin
                            state     <= S_FULL;
                            load_done <= 1'b1;
                            idx       <= '0;
                            row       <= '0;
                            col       <= '0;
                        end else begin
                            idx <= idx_nxt;
                            row <= row_nxt;
                            col <= col_nxt;
                        end
                    end
                end
                S_FULL: begin
                    if (op_valid) begin
                        case (op_in)
                            MAT_LOAD: begin
                                state <= S_LOAD;
                                idx   <= '0;
                                row   <= '0;
                                col   <= '0;
                            end
                            MAT_STORE: state <= S_STORE;
                            // Dropping the matrix is logical only; data stays.
                            MAT_NOP:   state <= S_IDLE;
                            default:   cmd_error <= 1'b1;
                        endcase
                    end
                end
                S_STORE: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state      <= S_FULL;
                            store_done <= 1'b1;
                            idx        <= '0;
                            row        <= '0;
                            col        <= '0;
                        end else begin
                            idx <= idx_nxt;
                            row <= row_nxt;
                            col <= col_nxt;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status and handshake outputs decode straight from the state register.
    assign op_ready  = (state == S_IDLE) || (state == S_FULL);
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_STORE);
    assign busy      = (state == S_LOAD) || (state == S_STORE);
    assign full      = (state == S_FULL);
    assign state_dbg = state;

    // Store payload follows the registered position, so it is stable while stalled.
    assign out_data = buffer[idx];
    assign out_row  = row;
    assign out_col  = col;

endmodule
